// File: rtl/apb_timer_unit_if.sv
// apb_timer_unit_if
//   APB bus bundle between the bridge (master) and the timer (slave).
//   Parameter APB_ADDR_WIDTH sets the PADDR width (default 12).
//   Signals:
//     PADDR   byte address            (master -> slave)
//     PWDATA  32-bit write data       (master -> slave)
//     PWRITE  1 = write               (master -> slave)
//     PSEL    slave select            (master -> slave)
//     PENABLE access phase            (master -> slave)
//     PRDATA  32-bit read data        (slave -> master)
//     PREADY  transfer complete       (slave -> master)
//     PSLVERR transfer error          (slave -> master)
interface apb_timer_unit_if #(
  parameter int APB_ADDR_WIDTH = 12
) ();
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_unit.sv
// apb_timer_unit
//   32-bit prescaled up-counter with compare match (one-shot or auto-reload),
//   overflow flag and level interrupt, behind a zero-wait-state APB slave.
//   Register map (PADDR[4:2]): 0 CTRL, 1 PRESC, 2 CMP, 3 COUNT, 4 STATUS,
//   5 CAPTURE; offsets 6 and 7 answer with PSLVERR.
//   Optional feature macro: APB_TIMER_CAPTURE_EN enables the capture input
//   (synchroniser + rising-edge detect, CAPTURE register, STATUS[2], CTRL[4]).
//   Ports:
//     clk_i      system clock, rising edge
//     rst_i      asynchronous active-high reset
//     apb        APB slave modport (PADDR/PWDATA/PWRITE/PSEL/PENABLE in,
//                PRDATA/PREADY/PSLVERR out)
//     capture_i  asynchronous capture strobe (ignored unless the macro is set)
//     irq_o      level interrupt, derived only from registered flags
module apb_timer_unit (
  input  logic            clk_i,
  input  logic            rst_i,
  apb_timer_unit_if.slave apb,
  input  logic            capture_i,
  output logic            irq_o
);

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_PRESC   = 3'd1;
  localparam logic [2:0] OFF_CMP     = 3'd2;
  localparam logic [2:0] OFF_COUNT   = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;
  localparam logic [2:0] OFF_CAPTURE = 3'd5;

`ifdef APB_TIMER_CAPTURE_EN
  localparam logic [4:0] CTRL_WMASK = 5'h1F;
`else
  localparam logic [4:0] CTRL_WMASK = 5'h0F;
`endif

  // CTRL bits: [0] EN, [1] AUTO_RELOAD, [2] MATCH_IE, [3] OVF_IE, [4] CAP_IE
  logic [4:0]  ctrl_q,   ctrl_d;
  logic [15:0] presc_q,  presc_d;
  logic [15:0] pcnt_q,   pcnt_d;
  logic [31:0] cmp_q,    cmp_d;
  logic [31:0] count_q,  count_d;
  // STATUS bits: [0] MATCH, [1] OVF, [2] CAP
  logic [2:0]  status_q, status_d;

  logic [2:0]  offset;
  logic        access, mapped, wr_en, rd_en;
  logic        wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
  logic        tick, match_hit, ovf_hit, cap_hit;
  logic [31:0] rdata;
  logic        paddr_unused;

  // Only PADDR[4:2] take part in decoding; fold the rest away.
  assign paddr_unused = ^apb.PADDR;

  // Address decode and APB access qualification.
  always_comb begin
    offset    = apb.PADDR[4:2];
    access    = apb.PSEL & apb.PENABLE;
    mapped    = (offset <= OFF_CAPTURE);
    wr_en     = access & apb.PWRITE & mapped;
    rd_en     = access & ~apb.PWRITE;
    wr_ctrl   = wr_en & (offset == OFF_CTRL);
    wr_presc  = wr_en & (offset == OFF_PRESC);
    wr_cmp    = wr_en & (offset == OFF_CMP);
    wr_count  = wr_en & (offset == OFF_COUNT);
    wr_status = wr_en & (offset == OFF_STATUS);
  end

  // Tick and event detection; the match compare always uses the pre-write COUNT.
  always_comb begin
    tick      = ctrl_q[0] & (pcnt_q == presc_q);
    match_hit = tick & (count_q == cmp_q);
    ovf_hit   = tick & ~match_hit & (count_q == 32'hFFFF_FFFF);
  end

`ifdef APB_TIMER_CAPTURE_EN
  logic        cap_sync1_q, cap_sync2_q, cap_prev_q;
  logic [31:0] capture_q;

  assign cap_hit = cap_sync2_q & ~cap_prev_q;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_sync1_q <= 1'b0;
      cap_sync2_q <= 1'b0;
      cap_prev_q  <= 1'b0;
    end else begin
      cap_sync1_q <= capture_i;
      cap_sync2_q <= cap_sync1_q;
      cap_prev_q  <= cap_sync2_q;
    end
  end

  // CAPTURE snapshots the current COUNT on a synchronised rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      capture_q <= 32'h0000_0000;
    end else if (cap_hit) begin
      capture_q <= count_q;
    end else begin
      capture_q <= capture_q;
    end
  end
`else
  logic capture_unused;

  assign capture_unused = capture_i;
  assign cap_hit        = 1'b0;
`endif

  // Next-state logic for all software-visible registers and the prescaler.
  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    count_d  = count_q;
    status_d = status_q;
    pcnt_d   = pcnt_q;

    if (wr_ctrl) begin
      ctrl_d = apb.PWDATA[4:0] & CTRL_WMASK;
    end else begin
      ctrl_d = ctrl_q;
    end
    // One-shot: a match without auto-reload stops the timer.
    if (match_hit & ~ctrl_q[1]) begin
      ctrl_d[0] = 1'b0;
    end else begin
      ctrl_d[0] = ctrl_d[0];
    end

    if (wr_presc) begin
      presc_d = apb.PWDATA[15:0];
    end else begin
      presc_d = presc_q;
    end

    if (wr_cmp) begin
      cmp_d = apb.PWDATA;
    end else begin
      cmp_d = cmp_q;
    end

    // A software COUNT load beats the tick update in the same cycle.
    if (wr_count) begin
      count_d = apb.PWDATA;
    end else if (match_hit) begin
      count_d = 32'h0000_0000;
    end else if (tick) begin
      count_d = count_q + 32'h0000_0001;
    end else begin
      count_d = count_q;
    end

    if (wr_presc | wr_count) begin
      pcnt_d = 16'h0000;
    end else if (~ctrl_q[0] | tick) begin
      pcnt_d = 16'h0000;
    end else begin
      pcnt_d = pcnt_q + 16'h0001;
    end

    // W1C first, then hardware sets OR in so a simultaneous set wins.
    if (wr_status) begin
      status_d = status_q & ~apb.PWDATA[2:0];
    end else begin
      status_d = status_q;
    end
    status_d = status_d | {cap_hit, ovf_hit, match_hit};
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= 5'h00;
      presc_q  <= 16'h0000;
      pcnt_q   <= 16'h0000;
      cmp_q    <= 32'hFFFF_FFFF;
      count_q  <= 32'h0000_0000;
      status_q <= 3'b000;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      cmp_q    <= cmp_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  // Read-data multiplexer; unmapped offsets read 0.
  always_comb begin
    rdata = 32'h0000_0000;
    case (offset)
      OFF_CTRL:    rdata = {27'd0, ctrl_q};
      OFF_PRESC:   rdata = {16'd0, presc_q};
      OFF_CMP:     rdata = cmp_q;
      OFF_COUNT:   rdata = count_q;
      OFF_STATUS:  rdata = {29'd0, status_q};
`ifdef APB_TIMER_CAPTURE_EN
      OFF_CAPTURE: rdata = capture_q;
`else
      OFF_CAPTURE: rdata = 32'h0000_0000;
`endif
      default:     rdata = 32'h0000_0000;
    endcase
  end

  assign apb.PRDATA  = rd_en ? rdata : 32'h0000_0000;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & ~mapped;

  assign irq_o = (status_q[0] & ctrl_q[2])
               | (status_q[1] & ctrl_q[3])
               | (status_q[2] & ctrl_q[4]);

endmodule

// File: tb/tb_apb_timer_unit.sv
// tb_apb_timer_unit
//   Self-checking bench: register-access vector table, hand-written timing
//   sequences (auto-reload, one-shot, overflow, W1C race, capture, reset
//   during a transfer) and randomized configurations checked against an
//   arithmetic model of the timer.
module tb_apb_timer_unit;

  logic clk_i = 1'b0;
  logic rst_i;
  logic capture_i;
  logic irq_o;

  apb_timer_unit_if bus ();

  apb_timer_unit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .apb       (bus.slave),
    .capture_i (capture_i),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter: after rising edge k, cyc == k.
  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int unsigned wcyc;      // edge on which the last write committed
  logic        irq_smp;   // irq_o seen at the last read sample point

`ifdef APB_TIMER_CAPTURE_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_001F;
  localparam bit          CAP_ON    = 1'b1;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
  localparam bit          CAP_ON    = 1'b0;
`endif

  localparam logic [2:0] O_CTRL = 3'd0, O_PRESC = 3'd1, O_CMP = 3'd2,
                         O_COUNT = 3'd3, O_STATUS = 3'd4, O_CAP = 3'd5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [2:0] off, input logic [31:0] data, output logic err);
    @(posedge clk_i); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = {7'd0, off, 2'b00}; bus.PWDATA = data;
    @(posedge clk_i); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk_i);
    err = bus.PSLVERR;
    @(posedge clk_i); #1;
    wcyc = cyc;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    logic e;
    apb_write(off, data, e);
  endtask

  task automatic apb_read(input logic [2:0] off, output logic [31:0] data,
                          output logic err, output int unsigned scyc);
    @(posedge clk_i); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = {7'd0, off, 2'b00};
    @(posedge clk_i); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk_i);
    data = bus.PRDATA; err = bus.PSLVERR; scyc = cyc; irq_smp = irq_o;
    @(posedge clk_i); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Wait (bounded) for irq_o to go high; returns the edge count or all-ones.
  task automatic wait_irq(output int unsigned at);
    at = 32'hFFFF_FFFF;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (irq_o) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Timer behaviour n edges after enabling, from the counting rules:
  // T ticks have elapsed; the match fires on tick d+1 where d is the
  // modular distance from the start value to CMP.
  task automatic model(input longint n, input int p, input logic [31:0] cmpv,
                       input logic [31:0] c0, input bit ar,
                       output logic [31:0] cnt, output bit m, output bit o, output bit en);
    longint t, d;
    t = n / longint'(p + 1);
    d = (longint'(cmpv) - longint'(c0) + 64'd4294967296) % 64'd4294967296;
    if (t <= d) begin
      cnt = 32'(longint'(c0) + t);
      m   = 1'b0;
      o   = (longint'(c0) + t) > 64'h0000_0000_FFFF_FFFF;
      en  = 1'b1;
    end else begin
      m = 1'b1;
      o = (c0 > cmpv);
      if (ar) begin
        cnt = 32'((t - d - 1) % (longint'(cmpv) + 1));
        en  = 1'b1;
      end else begin
        cnt = 32'h0;
        en  = 1'b0;
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int unsigned sc, w, at;

    // Register access table, applied straight after reset.
    vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'd6, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'd7, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'd6, 32'h0000_0001, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 3'd2, 32'h0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 3'd2, 32'h1234_5678, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'd2, 32'h0, 32'h1234_5678, 1'b0});
    vecs.push_back('{1'b1, 3'd1, 32'hABCD_1234, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0000_1234, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFE, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0, 32'hFFFF_FFFE & CTRL_MASK, 1'b0});
    vecs.push_back('{1'b1, 3'd3, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 32'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 3'd5, 32'h0000_0055, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 3'd4, 32'h0000_0007, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0000_0000, 1'b0});

    rst_i = 1'b1; capture_i = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 12'h000; bus.PWDATA = 32'h0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    check("reset_irq", {31'd0, irq_o}, 32'd0);
    check("reset_pready", {31'd0, bus.PREADY}, 32'd1);
    check("idle_prdata", bus.PRDATA, 32'd0);
    check("idle_pslverr", {31'd0, bus.PSLVERR}, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].off, vecs[i].data, err);
        check($sformatf("vec%0d_wr_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      end else begin
        apb_read(vecs[i].off, rd, err, sc);
        check($sformatf("vec%0d_rd_data", i), rd, vecs[i].exp);
        check($sformatf("vec%0d_rd_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      end
    end

    // Reset asserted in the access phase of a CMP write: nothing survives.
    wr(O_PRESC, 32'h0000_0077);
    @(posedge clk_i); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = {7'd0, O_CMP, 2'b00}; bus.PWDATA = 32'h0;
    @(posedge clk_i); #1;
    bus.PENABLE = 1'b1;
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    apb_read(O_CMP, rd, err, sc);   check("rst_mid_cmp", rd, 32'hFFFF_FFFF);
    apb_read(O_PRESC, rd, err, sc); check("rst_mid_presc", rd, 32'h0);
    apb_read(O_COUNT, rd, err, sc); check("rst_mid_count", rd, 32'h0);

    // Auto-reload: PRESC=3, CMP=4 -> match every 20 cycles.
    wr(O_PRESC, 32'd3); wr(O_CMP, 32'd4); wr(O_CTRL, 32'h7);
    w = wcyc;
    wait_irq(at); check("ar_first_match", at - w, 32'd20);
    wr(O_STATUS, 32'h1);
    @(negedge clk_i); check("ar_w1c_irq", {31'd0, irq_o}, 32'd0);
    wait_irq(at); check("ar_second_match", at - w, 32'd40);
    wr(O_STATUS, 32'h1);
    @(negedge clk_i); check("ar_w1c2_irq", {31'd0, irq_o}, 32'd0);
    while (cyc < w + 57) begin @(posedge clk_i); #1; end
    wr(O_STATUS, 32'h1);          // commits on the third match edge
    @(negedge clk_i); check("w1c_race_irq", {31'd0, irq_o}, 32'd1);
    apb_read(O_STATUS, rd, err, sc); check("w1c_race_status", rd, 32'h1);
    apb_read(O_COUNT, rd, err, sc);  check("ar_count_after", rd, (sc - w - 60) / 4);

    // One-shot.
    wr(O_CTRL, 32'h0); wr(O_STATUS, 32'h7); wr(O_COUNT, 32'h0); wr(O_CTRL, 32'h5);
    w = wcyc;
    wait_irq(at); check("os_match", at - w, 32'd20);
    repeat (30) @(posedge clk_i);
    apb_read(O_CTRL, rd, err, sc);   check("os_ctrl", rd, 32'h4);
    apb_read(O_COUNT, rd, err, sc);  check("os_count", rd, 32'h0);
    apb_read(O_STATUS, rd, err, sc); check("os_status", rd, 32'h1);

    // Overflow near the wrap.
    wr(O_CTRL, 32'h0); wr(O_STATUS, 32'h7); wr(O_PRESC, 32'h0);
    wr(O_CMP, 32'd5); wr(O_COUNT, 32'hFFFF_FFFE); wr(O_CTRL, 32'h9);
    w = wcyc;
    wait_irq(at); check("ovf_irq_time", at - w, 32'd2);
    apb_read(O_STATUS, rd, err, sc); check("ovf_flag", rd & 32'h2, 32'h2);
    wr(O_STATUS, 32'h2);
    @(negedge clk_i); check("ovf_w1c_irq", {31'd0, irq_o}, 32'd0);

    // Capture input.
    wr(O_CTRL, 32'h0); wr(O_STATUS, 32'h7); wr(O_PRESC, 32'h0000_FFFF);
    wr(O_COUNT, 32'd100); wr(O_CTRL, 32'h1);
    @(posedge clk_i); #1 capture_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 capture_i = 1'b0;
    repeat (5) @(posedge clk_i);
    apb_read(O_CAP, rd, err, sc);    check("cap_value", rd, CAP_ON ? 32'd100 : 32'd0);
    apb_read(O_STATUS, rd, err, sc); check("cap_status", rd, CAP_ON ? 32'h4 : 32'h0);
    wr(O_CTRL, 32'h11);
    @(negedge clk_i); check("cap_irq", {31'd0, irq_o}, {31'd0, CAP_ON});
    wr(O_STATUS, 32'h4);
    apb_read(O_STATUS, rd, err, sc); check("cap_w1c", rd, 32'h0);

    // Randomized configurations against the arithmetic model.
    for (int it = 0; it < 25; it++) begin
      int          p;
      logic [31:0] cv, c0, ecnt;
      bit          ar, mie, oie, em, eo, een;
      p  = int'($urandom_range(3, 0));
      cv = 32'($urandom_range(12, 0));
      if ($urandom_range(1, 0) == 0) c0 = 32'($urandom_range(int'(cv), 0));
      else                           c0 = 32'hFFFF_FFFF - 32'($urandom_range(5, 0));
      ar = 1'($urandom_range(1, 0)); mie = 1'($urandom_range(1, 0)); oie = 1'($urandom_range(1, 0));
      wr(O_CTRL, 32'h0); wr(O_STATUS, 32'h7); wr(O_PRESC, 32'(p));
      wr(O_CMP, cv); wr(O_COUNT, c0);
      wr(O_CTRL, {28'd0, oie, mie, ar, 1'b1});
      w = wcyc;
      repeat ($urandom_range(60, 0)) @(posedge clk_i);
      apb_read(O_COUNT, rd, err, sc);
      model(longint'(sc - w), p, cv, c0, ar, ecnt, em, eo, een);
      check($sformatf("rnd%0d_count", it), rd, ecnt);
      check($sformatf("rnd%0d_irq", it), {31'd0, irq_smp}, {31'd0, (em & mie) | (eo & oie)});
      apb_read(O_STATUS, rd, err, sc);
      model(longint'(sc - w), p, cv, c0, ar, ecnt, em, eo, een);
      check($sformatf("rnd%0d_status", it), rd, {30'd0, eo, em});
      apb_read(O_CTRL, rd, err, sc);
      model(longint'(sc - w), p, cv, c0, ar, ecnt, em, eo, een);
      check($sformatf("rnd%0d_ctrl", it), rd, {28'd0, oie, mie, ar, een});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
